// File: rtl/lock_code_ctrl_if.sv
// rtl/lock_code_ctrl_if.sv - key event input and lock status bundle for lock_code_ctrl
interface lock_code_ctrl_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       unlocked;
  logic       alarm;
  logic [3:0] digit_cnt;
  logic [2:0] err_cnt;
  logic [1:0] state;

  modport master (
    output key_valid, key_code,
    input  unlocked, alarm, digit_cnt, err_cnt, state
  );

  modport slave (
    input  key_valid, key_code,
    output unlocked, alarm, digit_cnt, err_cnt, state
  );
endinterface

// File: rtl/lock_code_ctrl.sv
// rtl/lock_code_ctrl.sv - keypad combination lock with lockout, auto-relock and code change
module lock_code_ctrl #(
  parameter int                     PW_DIGITS      = 4,
  parameter logic [4*PW_DIGITS-1:0] DEFAULT_PW     = 16'h1234,
  parameter int                     MAX_TRIES      = 3,
  parameter int                     LOCKOUT_CYCLES = 50_000_000,
  parameter int                     RELOCK_CYCLES  = 500_000_000
) (
  input logic              clock,
  input logic              rst_n,
  lock_code_ctrl_if.slave  bus
);

  localparam int BW   = 4 * PW_DIGITS;
  localparam int TMAX = (LOCKOUT_CYCLES > RELOCK_CYCLES) ? LOCKOUT_CYCLES : RELOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [3:0] KEY_LOCK  = 4'hC;
  localparam logic [3:0] KEY_SET   = 4'hD;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_SET_PW   = 2'd2,
    ST_LOCKOUT  = 2'd3
  } st_t;

  st_t             st_q, st_d;
  logic [BW-1:0]   entry_q, entry_d;
  logic [BW-1:0]   code_q, code_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [2:0]      err_q, err_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            unl_q, alm_q;
  logic            full;

  assign full = (cnt_q == 4'(PW_DIGITS));

  always_comb begin
    st_d    = st_q;
    entry_d = entry_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    tmr_d   = tmr_q;

    if (st_q == ST_LOCKOUT) begin
      entry_d = '0;
      cnt_d   = '0;
      if (tmr_q == TW'(LOCKOUT_CYCLES - 1)) begin
        st_d  = ST_LOCKED;
        err_d = '0;
        tmr_d = '0;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end else if (st_q != ST_LOCKED && tmr_q == TW'(RELOCK_CYCLES - 1)) begin
      // timeout beats any key arriving in the same cycle
      st_d    = ST_LOCKED;
      entry_d = '0;
      cnt_d   = '0;
      tmr_d   = '0;
    end else begin
      if (st_q == ST_LOCKED || bus.key_valid)
        tmr_d = '0;
      else
        tmr_d = tmr_q + 1'b1;

      if (bus.key_valid) begin
        if (bus.key_code <= 4'd9) begin
          if (!full) begin
            entry_d = (entry_q << 4) | BW'(bus.key_code);
            cnt_d   = cnt_q + 4'd1;
          end
        end else begin
          case (bus.key_code)
            KEY_ENTER: begin
              entry_d = '0;
              cnt_d   = '0;
              if (st_q == ST_LOCKED) begin
                if (full && entry_q == code_q) begin
                  st_d  = ST_UNLOCKED;
                  err_d = '0;
                end else begin
                  err_d = err_q + 3'd1;
                  if (err_q + 3'd1 == 3'(MAX_TRIES))
                    st_d = ST_LOCKOUT;
                end
              end else if (st_q == ST_SET_PW) begin
                if (full)
                  code_d = entry_q;
                st_d = ST_UNLOCKED;
              end
            end
            KEY_CLEAR: begin
              entry_d = '0;
              cnt_d   = '0;
            end
            KEY_LOCK: begin
              if (st_q != ST_LOCKED) begin
                st_d    = ST_LOCKED;
                entry_d = '0;
                cnt_d   = '0;
              end
            end
            KEY_SET: begin
              if (st_q == ST_UNLOCKED) begin
                st_d    = ST_SET_PW;
                entry_d = '0;
                cnt_d   = '0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_LOCKED;
      entry_q <= '0;
      code_q  <= DEFAULT_PW;
      cnt_q   <= '0;
      err_q   <= '0;
      tmr_q   <= '0;
      unl_q   <= 1'b0;
      alm_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      entry_q <= entry_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      tmr_q   <= tmr_d;
      unl_q   <= (st_d == ST_UNLOCKED) || (st_d == ST_SET_PW);
      alm_q   <= (st_d == ST_LOCKOUT);
    end
  end

  assign bus.unlocked  = unl_q;
  assign bus.alarm     = alm_q;
  assign bus.digit_cnt = cnt_q;
  assign bus.err_cnt   = err_q;
  assign bus.state     = st_q;

endmodule

// File: tb/tb_lock_code_ctrl.sv
// tb/tb_lock_code_ctrl.sv - directed and random checks of lock_code_ctrl against a digit-list model
module tb_lock_code_ctrl;
  localparam int          PW   = 4;
  localparam int          MAXT = 3;
  localparam int          LK   = 20;
  localparam int          RL   = 50;
  localparam logic [15:0] DEF  = 16'h1234;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  lock_code_ctrl_if bus();

  lock_code_ctrl #(
    .PW_DIGITS(PW), .DEFAULT_PW(DEF), .MAX_TRIES(MAXT),
    .LOCKOUT_CYCLES(LK), .RELOCK_CYCLES(RL)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // model: 0 locked, 1 unlocked, 2 set-code, 3 lockout; timers as absolute edge deadlines
  int m_state, m_err, edge_no, deadline;
  int m_buf[$];
  int m_stored[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_err    = 0;
    deadline = 0;
    m_buf    = {};
    m_stored = {};
    for (int i = 0; i < PW; i++) m_stored.push_back(int'((DEF >> (4 * (PW - 1 - i))) & 16'hF));
  endtask

  function automatic bit code_ok();
    if (m_buf.size() != PW) return 1'b0;
    for (int i = 0; i < PW; i++) if (m_buf[i] != m_stored[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input bit v, input int k);
    edge_no++;
    if (m_state == 3) begin
      m_buf = {};
      if (edge_no == deadline) begin m_state = 0; m_err = 0; end
      return;
    end
    if (m_state != 0 && edge_no == deadline) begin
      m_state = 0;
      m_buf = {};
      return;
    end
    if (!v) return;
    if (m_state != 0) deadline = edge_no + RL;
    if (k <= 9) begin
      if (m_buf.size() < PW) m_buf.push_back(k);
    end else if (k == 11) begin
      m_buf = {};
    end else if (k == 10) begin
      if (m_state == 0) begin
        if (code_ok()) begin
          m_state = 1; m_err = 0; deadline = edge_no + RL;
        end else begin
          m_err++;
          if (m_err == MAXT) begin m_state = 3; deadline = edge_no + LK; end
        end
      end else if (m_state == 2) begin
        if (m_buf.size() == PW) m_stored = m_buf;
        m_state = 1;
      end
      m_buf = {};
    end else if (k == 12) begin
      if (m_state != 0) begin m_state = 0; m_buf = {}; end
    end else if (k == 13) begin
      if (m_state == 1) begin m_state = 2; m_buf = {}; end
    end
  endtask

  task automatic check_outputs();
    chk("state", 32'(bus.state), 32'(m_state));
    chk("unlocked", 32'(bus.unlocked), 32'(m_state == 1 || m_state == 2));
    chk("alarm", 32'(bus.alarm), 32'(m_state == 3));
    chk("digit_cnt", 32'(bus.digit_cnt), 32'(m_buf.size()));
    chk("err_cnt", 32'(bus.err_cnt), 32'(m_err));
  endtask

  task automatic step(input bit v, input int k);
    bus.key_valid = v;
    bus.key_code  = 4'(k);
    @(posedge clock);
    model_step(v, k);
    #1;
    check_outputs();
    bus.key_valid = 1'b0;
  endtask

  task automatic press(input int k);
    step(1'b1, k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0);
  endtask

  task automatic enter_code(input int code, input int n);
    for (int i = 0; i < n; i++) press((code >> (4 * (n - 1 - i))) & 15);
  endtask

  // async reset pulse, called #1 after an edge; outputs must clear before the next edge
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_unlocked", 32'(bus.unlocked), 32'd0);
    chk("rst_alarm", 32'(bus.alarm), 32'd0);
    check_outputs();
    @(posedge clock);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    edge_no = 0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clock);
    #3;
    rst_n = 1'b1;

    // correct default code
    enter_code('h1234, 4);
    press(10);
    chk("t1_unlocked", 32'(bus.unlocked), 32'd1);
    press(12);

    // three wrong tries, keys ignored during lockout, then timed exit
    enter_code('h1235, 4); press(10);
    enter_code('h1235, 4); press(10);
    chk("t2_err2", 32'(bus.err_cnt), 32'd2);
    enter_code('h1235, 4); press(10);
    chk("t2_alarm", 32'(bus.alarm), 32'd1);
    press(1); press(2); press(10);
    idle(LK);
    chk("t2_alarm_off", 32'(bus.alarm), 32'd0);
    chk("t2_err_clr", 32'(bus.err_cnt), 32'd0);

    // short entry fails, overlong entry truncated
    enter_code('h123, 3); press(10);
    chk("t3_short_err", 32'(bus.err_cnt), 32'd1);
    enter_code('h12349, 5);
    chk("t3_cnt_sat", 32'(bus.digit_cnt), 32'd4);
    press(10);
    chk("t3_unlocked", 32'(bus.unlocked), 32'd1);

    // code change, old code rejected, new code accepted
    press(13); enter_code('h9876, 4); press(10); press(12);
    enter_code('h1234, 4); press(10);
    chk("t4_old_rejected", 32'(bus.err_cnt), 32'd1);
    enter_code('h9876, 4); press(10);
    chk("t4_new_ok", 32'(bus.unlocked), 32'd1);

    // auto-relock after idle, kept alive by periodic keys
    idle(RL + 1);
    chk("t5_relocked", 32'(bus.unlocked), 32'd0);
    enter_code('h9876, 4); press(10);
    for (int i = 0; i < 3; i++) begin idle(39); press(14); end
    chk("t5_kept", 32'(bus.unlocked), 32'd1);
    press(12);

    // reset mid-entry and mid-lockout restores default code
    press(1); press(2);
    do_reset();
    enter_code('h9876, 4); press(10);
    chk("t6_default_back", 32'(bus.err_cnt), 32'd1);
    enter_code('h1111, 4); press(10);
    enter_code('h1111, 4); press(10);
    idle(5);
    do_reset();
    enter_code('h1234, 4); press(10);
    chk("t6_default_ok", 32'(bus.unlocked), 32'd1);

    // random traffic biased towards the stored code
    for (int n = 0; n < 700; n++) begin
      int r;
      r = int'($urandom_range(0, 199));
      if (r < 4) idle(int'($urandom_range(20, 60)));
      else if (r < 60) idle(1);
      else if (r < 120) press(m_stored[m_buf.size() % PW]);
      else if (r < 145) press(10);
      else if (r < 198) press(int'($urandom_range(0, 15)));
      else do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lock_code_ctrl.md
Name: lock_code_ctrl

Overview:
- Keypad-driven combination-lock controller; sits directly upstream of the 16x16 dot-matrix lock/unlock icon driver.
- Consumes debounced single-cycle key events, checks a PW_DIGITS-digit BCD code against a stored code, and drives the `unlocked` level.
- `unlocked` feeds the icon driver's `No` select: 0 = locked icon, 1 = open icon.
- Also handles wrong-try lockout with alarm, auto-relock on inactivity, and in-field code change.

Parameters:
- PW_DIGITS, 4, number of BCD digits in the code (1..8).
- DEFAULT_PW, 16'h1234, code loaded at reset; width 4*PW_DIGITS, one digit per nibble, first-entered digit in the MS nibble.
- MAX_TRIES, 3, consecutive failed Enters that trigger lockout (1..7).
- LOCKOUT_CYCLES, 50_000_000, clock cycles spent in LOCKOUT.
- RELOCK_CYCLES, 500_000_000, key-idle cycles in UNLOCKED/SET_PW before auto-relock.

Ports:
- clock, input, 1, system clock; all state on posedge.
- rst_n, input, 1, asynchronous active-low reset.
- key_valid, input, 1, one-cycle pulse per key press.
- key_code, input, 4, key value, sampled when key_valid=1:
  - 0-9: digit
  - A: Enter
  - B: Clear
  - C: Lock
  - D: Set-code
  - E, F: ignored
- unlocked, output, 1, 1 = door open; drives icon driver `No`.
- alarm, output, 1, 1 while in LOCKOUT.
- digit_cnt, output, 4, digits currently buffered (0..PW_DIGITS).
- err_cnt, output, 3, consecutive failed attempts.
- state, output, 2, LOCKED=0, UNLOCKED=1, SET_PW=2, LOCKOUT=3.

Behaviour:
- Reset (rst_n=0, async): state=LOCKED, unlocked=0, alarm=0, digit_cnt=0, err_cnt=0, entry buffer=0, stored code=DEFAULT_PW, timers=0.
- All outputs are registered. `unlocked` and `alarm` are decoded from the registered state, so they change the cycle after the deciding key_valid (latency 1).
- Digit key, any state except LOCKOUT:
  - If digit_cnt<PW_DIGITS: buffer <= {buffer[4*PW_DIGITS-5:0], digit}; digit_cnt+1.
  - If digit_cnt==PW_DIGITS: key ignored, buffer unchanged.
- Clear (B): buffer=0, digit_cnt=0. State and err_cnt unchanged.
- LOCKED:
  - Enter with digit_cnt==PW_DIGITS and buffer==stored → UNLOCKED; err_cnt=0.
  - Any other Enter (mismatch or short entry) → err_cnt+1.
    - If the new err_cnt==MAX_TRIES → LOCKOUT.
    - Otherwise stay LOCKED.
  - Every Enter clears the buffer and digit_cnt.
  - C and D are ignored.
- LOCKOUT:
  - alarm=1; all keys ignored; buffer held at 0.
  - Counter runs 0..LOCKOUT_CYCLES-1, then → LOCKED with err_cnt=0.
  - alarm drops the cycle after exit.
- UNLOCKED:
  - C → LOCKED.
  - D → SET_PW, buffer cleared.
  - Enter → buffer cleared only.
- Relock timer (UNLOCKED and SET_PW):
  - Cleared on entry to either state and on every key_valid, including ignored codes.
  - Increments otherwise.
  - Reaching RELOCK_CYCLES-1 → LOCKED, buffer discarded.
- SET_PW (unlocked stays 1):
  - Enter with digit_cnt==PW_DIGITS → stored <= buffer, → UNLOCKED.
  - Enter with a short entry → stored unchanged, → UNLOCKED.
  - Buffer cleared on exit either way.
  - C → LOCKED; partial entry discarded, stored unchanged.
- Priority: when a key_valid and a relock or lockout timeout occur in the same cycle, the timeout wins and the key is dropped.
- Entering LOCKED from any state clears buffer and digit_cnt.
- Only the LOCKED path touches err_cnt. It saturates at MAX_TRIES because LOCKOUT is entered at that point.
- Stored code survives everything except reset.
- Reset asserted mid-entry or mid-lockout returns immediately to reset values, including stored=DEFAULT_PW.

Test Plan (LOCKOUT_CYCLES=20, RELOCK_CYCLES=50):
1. Reset, keys 1,2,3,4,A → unlocked=1 one cycle after A; err_cnt=0; digit_cnt=0.
2. Keys 1,2,3,5,A three times → err_cnt 1,2 then state=LOCKOUT, alarm=1. Keys during LOCKOUT are ignored. After 20 cycles: alarm=0, LOCKED, err_cnt=0.
3. Keys 1,2,3,A → counted as a failure (err_cnt=1). Then 1,2,3,4,9,A → the 9 is ignored, digit_cnt stays 4, unlock succeeds.
4. Unlock, then D,9,8,7,6,A → stored=9876. C → LOCKED. Then 1,2,3,4,A fails; 9,8,7,6,A unlocks.
5. Unlock, then no keys for 50 cycles → unlocked=0 one cycle later. Repeat with a key every 40 cycles → stays unlocked.
6. Assert rst_n low mid-way through 1,2 entry and mid-LOCKOUT → all outputs 0 immediately. DEFAULT_PW is restored even after a prior code change.
